// File: rtl/soc_uart0_rx_capture.sv
// 8N1 UART receiver for the SoC uart0 TX pad: fixed-divider bit timing,
// byte FIFO with a valid/ready drain port, frame-error and overflow flags.
module soc_uart0_rx_capture #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_pad_clk,
  input  logic             i_pad_rst,
  input  logic             i_uart_sin,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic             o_frame_err,
  output logic             o_overflow,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_fifo_cnt
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic             r_sync1, r_sync2, r_prev;
  state_t           r_state, w_state_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_push, w_push_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CNT_W-1:0] r_fcnt;
  logic             r_ovf;
  logic             w_fall, w_tick, w_full, w_pop, w_acc;

  assign w_fall = r_prev & ~r_sync2;
  assign w_tick = (r_cnt == 16'd0);

  // Input synchronizer and edge-detect copy
  always_ff @(posedge i_pad_clk) begin
    if (i_pad_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_uart_sin;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receiver state register
  always_ff @(posedge i_pad_clk) begin
    if (i_pad_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_push  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_push  <= w_push_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Receiver next-state logic; every sample is taken at mid-bit (counter==0)
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_cnt_nxt   = HALF_LOAD;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else if (!r_sync2) begin
          w_cnt_nxt   = FULL_LOAD;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else begin
          w_shift_nxt[r_idx] = r_sync2;
          w_cnt_nxt          = FULL_LOAD;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else if (r_sync2) begin
          w_push_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = S_BREAK;
        end
      end
      S_BREAK: begin
        if (r_sync2) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
  assign w_full = (r_fcnt == CNT_W'(FIFO_DEPTH));
  assign w_pop  = (r_fcnt != '0) & i_rx_ready;
  assign w_acc  = r_push & (~w_full | w_pop);

  // Byte FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge i_pad_clk) begin
    if (i_pad_rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'd0;
      end
    end else begin
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      if (w_acc) begin
        r_mem[r_wr] <= r_shift;
        r_wr        <= r_wr + AW'(1);
      end
      if (r_push && !w_acc) begin
        r_ovf <= 1'b1;
      end
      r_fcnt <= r_fcnt + CNT_W'(w_acc) - CNT_W'(w_pop);
    end
  end

  assign o_rx_data   = r_mem[r_rd];
  assign o_rx_valid  = (r_fcnt != '0);
  assign o_frame_err = r_ferr;
  assign o_overflow  = r_ovf;
  assign o_busy      = (r_state != S_IDLE);
  assign o_fifo_cnt  = r_fcnt;

endmodule

// File: tb/tb_soc_uart0_rx_capture.sv
// Self-checking bench for soc_uart0_rx_capture: random bytes framed as 8N1
// and compared against a queue-based model of the receive FIFO.
module tb_soc_uart0_rx_capture;
  localparam int BD    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          i_pad_rst = 1'b1;
  logic          i_uart_sin = 1'b1;
  logic          i_rx_ready = 1'b0;
  logic [7:0]    o_rx_data;
  logic          o_rx_valid, o_frame_err, o_overflow, o_busy;
  logic [CW-1:0] o_fifo_cnt;

  int checks = 0;
  int passes = 0;
  int ferr_cnt = 0;
  int busy_cyc = 0;
  logic rand_ready = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic model_ovf;

  always #5 clk = ~clk;

  soc_uart0_rx_capture #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .i_pad_clk(clk), .i_pad_rst(i_pad_rst), .i_uart_sin(i_uart_sin),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .o_frame_err(o_frame_err), .o_overflow(o_overflow), .o_busy(o_busy),
    .o_fifo_cnt(o_fifo_cnt));

  // Record every accepted byte and event, sampled mid-cycle
  always @(negedge clk) begin
    if (!i_pad_rst) begin
      if (o_rx_valid && i_rx_ready) got_q.push_back(o_rx_data);
      if (o_frame_err) ferr_cnt++;
      if (o_busy) busy_cyc++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) i_rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    i_uart_sin = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 8; i++) begin
      i_uart_sin = b[i];
      repeat (BD) tick();
    end
    i_uart_sin = stop_v;
    repeat (BD) tick();
  endtask

  // Model of the FIFO seen from the writer side while nothing drains it
  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    repeat (4) tick();
    while ((o_rx_valid || o_busy) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) $display("FAIL %s_drain_timeout: cnt=%0d busy=%0b, required empty and idle", tag, o_fifo_cnt, o_busy);
    else passes++;
  endtask

  task automatic compare_stream(input string tag);
    checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s_count: got %0d bytes, required %0d", tag, got_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL %s_byte%0d: got %02h, required %02h", tag, i, got_q[i], exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_reset();
    i_pad_rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({o_rx_data, o_rx_valid, o_frame_err, o_overflow, o_busy, o_fifo_cnt} !== {8'h00, 4'b0000, CW'(0)})
      $display("FAIL reset_values: data=%02h v=%0b fe=%0b ov=%0b busy=%0b cnt=%0d, required all zero",
               o_rx_data, o_rx_valid, o_frame_err, o_overflow, o_busy, o_fifo_cnt);
    else passes++;
    i_pad_rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    got_q.delete(); exp_q.delete(); ferr_cnt = 0;
    i_rx_ready = 1'b1;
    send_frame(8'h55, 1'b1); exp_q.push_back(8'h55);
    repeat (BD) tick();
    send_frame(8'hA3, 1'b1); exp_q.push_back(8'hA3);
    wait_drain("basic");
    compare_stream("basic");
    checks++;
    if (ferr_cnt != 0 || o_overflow !== 1'b0)
      $display("FAIL basic_flags: frame_err pulses=%0d overflow=%0b, required 0 and 0", ferr_cnt, o_overflow);
    else passes++;
  endtask

  task automatic test_random();
    got_q.delete(); exp_q.delete(); ferr_cnt = 0;
    rand_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      exp_q.push_back(b);
      repeat (BD * $urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    i_rx_ready = 1'b1;
    wait_drain("random");
    compare_stream("random");
  endtask

  task automatic test_glitch();
    got_q.delete(); ferr_cnt = 0; busy_cyc = 0;
    i_rx_ready = 1'b1;
    i_uart_sin = 1'b0;
    repeat (2) tick();
    i_uart_sin = 1'b1;
    repeat (20) tick();
    checks++;
    if (busy_cyc < 1 || busy_cyc > 5) $display("FAIL glitch_busy: busy for %0d cycles, required 1..5", busy_cyc);
    else passes++;
    checks++;
    if (got_q.size() != 0 || ferr_cnt != 0 || o_busy !== 1'b0)
      $display("FAIL glitch_quiet: bytes=%0d frame_err=%0d busy=%0b, required 0/0/0", got_q.size(), ferr_cnt, o_busy);
    else passes++;
  endtask

  task automatic test_frame_err();
    int nonzero = 0;
    got_q.delete(); ferr_cnt = 0;
    i_rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_fifo_cnt != 0) nonzero++;
    end
    i_uart_sin = 1'b1;
    repeat (2 * BD) tick();
    checks++;
    if (ferr_cnt != 1) $display("FAIL ferr_pulses: got %0d, required 1", ferr_cnt);
    else passes++;
    checks++;
    if (nonzero != 0 || o_fifo_cnt !== CW'(0)) $display("FAIL ferr_fifo: cnt=%0d nonzero cycles=%0d, required 0", o_fifo_cnt, nonzero);
    else passes++;
    send_frame(8'h81, 1'b1);
    repeat (4) tick();
    checks++;
    if (o_fifo_cnt !== CW'(1) || o_rx_data !== 8'h81 || o_rx_valid !== 1'b1)
      $display("FAIL ferr_recover: cnt=%0d data=%02h valid=%0b, required 1/81/1", o_fifo_cnt, o_rx_data, o_rx_valid);
    else passes++;
    i_rx_ready = 1'b1;
    wait_drain("ferr");
    exp_q.delete(); exp_q.push_back(8'h81);
    compare_stream("ferr");
  endtask

  task automatic test_overflow();
    got_q.delete(); exp_q.delete(); model_ovf = 1'b0;
    i_rx_ready = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      send_frame(8'(k), 1'b1);
      model_push(8'(k));
    end
    repeat (4) tick();
    checks++;
    if (o_fifo_cnt !== CW'(exp_q.size())) $display("FAIL ovf_cnt: got %0d, required %0d", o_fifo_cnt, exp_q.size());
    else passes++;
    checks++;
    if (o_overflow !== model_ovf) $display("FAIL ovf_flag: got %0b, required %0b", o_overflow, model_ovf);
    else passes++;
    i_rx_ready = 1'b1;
    wait_drain("ovf");
    compare_stream("ovf");
    checks++;
    if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b, required 1", o_overflow);
    else passes++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b;
    int n = 0;
    i_pad_rst = 1'b1; tick(); tick(); i_pad_rst = 1'b0; tick();
    got_q.delete(); exp_q.delete();
    i_rx_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      exp_q.push_back(b);
    end
    repeat (4) tick();
    checks++;
    if (o_fifo_cnt !== CW'(DEPTH)) $display("FAIL full_cnt: got %0d, required %0d", o_fifo_cnt, DEPTH);
    else passes++;
    b = 8'h5A;
    i_uart_sin = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 8; i++) begin
      i_uart_sin = b[i];
      repeat (BD) tick();
    end
    i_uart_sin = 1'b1;
    while (o_busy && n < 3 * BD) begin
      tick();
      n++;
    end
    checks++;
    if (o_busy) $display("FAIL full_push_timeout: busy=%0b, required 0 within %0d cycles", o_busy, 3 * BD);
    else passes++;
    i_rx_ready = 1'b1;
    tick();
    i_rx_ready = 1'b0;
    exp_q.push_back(b);
    checks++;
    if (o_fifo_cnt !== CW'(DEPTH) || o_overflow !== 1'b0)
      $display("FAIL full_simul: cnt=%0d overflow=%0b, required %0d/0", o_fifo_cnt, o_overflow, DEPTH);
    else passes++;
    repeat (BD) tick();
    i_rx_ready = 1'b1;
    wait_drain("full");
    compare_stream("full");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    got_q.delete(); exp_q.delete();
    i_rx_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    repeat (4) tick();
    checks++;
    if (o_fifo_cnt !== CW'(3)) $display("FAIL rst_pre_cnt: got %0d, required 3", o_fifo_cnt);
    else passes++;
    b = 8'($urandom_range(0, 255));
    i_uart_sin = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 4; i++) begin
      i_uart_sin = b[i];
      repeat (BD) tick();
    end
    i_uart_sin = b[4];
    repeat (BD / 2) tick();
    checks++;
    if (o_busy !== 1'b1) $display("FAIL rst_pre_busy: got %0b, required 1", o_busy);
    else passes++;
    i_pad_rst = 1'b1;
    i_uart_sin = 1'b1;
    tick();
    i_pad_rst = 1'b0;
    checks++;
    if ({o_rx_data, o_rx_valid, o_frame_err, o_overflow, o_busy, o_fifo_cnt} !== {8'h00, 4'b0000, CW'(0)})
      $display("FAIL rst_mid_values: data=%02h v=%0b fe=%0b ov=%0b busy=%0b cnt=%0d, required all zero",
               o_rx_data, o_rx_valid, o_frame_err, o_overflow, o_busy, o_fifo_cnt);
    else passes++;
    i_rx_ready = 1'b1;
    repeat (12 * BD) tick();
    checks++;
    if (got_q.size() != 0 || o_fifo_cnt !== CW'(0)) $display("FAIL rst_no_byte: bytes=%0d cnt=%0d, required 0/0", got_q.size(), o_fifo_cnt);
    else passes++;
    send_frame(8'hE7, 1'b1);
    exp_q.push_back(8'hE7);
    wait_drain("rst");
    compare_stream("rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_push_pop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
